// File: rtl/button_bank_if.sv
// Pin-side bundle of button_bank: raw pins in, debounced level and
// single-cycle event pulses out, one bit per channel.
interface button_bank_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] PIN;
  logic [CHANNELS-1:0] STATE;
  logic [CHANNELS-1:0] PRESS;
  logic [CHANNELS-1:0] RELEASE;
  logic [CHANNELS-1:0] HOLD;
  logic [CHANNELS-1:0] REPEAT;

  modport master (
    output PIN,
    input  STATE, PRESS, RELEASE, HOLD, REPEAT
  );

  modport slave (
    input  PIN,
    output STATE, PRESS, RELEASE, HOLD, REPEAT
  );
endinterface

// File: rtl/button_bank.sv
// Multi-channel button front end: 2-FF sync, ms-tick debounce, and
// press/release/hold/repeat pulse generation per channel.
module button_bank #(
  parameter int CHANNELS        = 4,
  parameter bit ACTIVE_STATE    = 1'b1,
  parameter int CLOCKS_PER_USEC = 100,
  parameter int DEBOUNCE_MSEC   = 10,
  parameter int HOLD_MSEC       = 1000,
  parameter int REPEAT_MSEC     = 200
) (
  input  logic         CLK,
  input  logic         RESETN,
  button_bank_if.slave bus
);
  localparam int PRE_N = CLOCKS_PER_USEC * 1000;
  localparam int PW    = $clog2(PRE_N);
  localparam int DW    = $clog2(DEBOUNCE_MSEC + 1);
  localparam int HMAX  = (HOLD_MSEC > REPEAT_MSEC) ?
                         HOLD_MSEC : REPEAT_MSEC;
  localparam int HW    = $clog2(HMAX + 1);
  localparam logic [CHANNELS-1:0] IDLE_LVL =
    {CHANNELS{!ACTIVE_STATE}};

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } ch_state_e;

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;
  logic          tick;

  (* ASYNC_REG = "TRUE" *) logic [CHANNELS-1:0] sync1_q;
  (* ASYNC_REG = "TRUE" *) logic [CHANNELS-1:0] sync2_q;
  logic [CHANNELS-1:0] raw;

  logic [CHANNELS-1:0] state_q, state_d;
  logic [CHANNELS-1:0] press_q, press_d;
  logic [CHANNELS-1:0] rel_q, rel_d;
  logic [CHANNELS-1:0] hold_q, hold_d;
  logic [CHANNELS-1:0] rep_q, rep_d;
  logic [CHANNELS-1:0] rise, fall;

  logic [DW-1:0] deb_q  [CHANNELS];
  logic [DW-1:0] deb_d  [CHANNELS];
  logic [HW-1:0] hcnt_q [CHANNELS];
  logic [HW-1:0] hcnt_d [CHANNELS];
  ch_state_e     fsm_q  [CHANNELS];
  ch_state_e     fsm_d  [CHANNELS];

  assign tick  = (pre_q == PW'(PRE_N - 1));
  assign pre_d = tick ? '0 : pre_q + 1'b1;
  assign raw   = sync2_q ~^ {CHANNELS{ACTIVE_STATE}};

  always_comb begin
    state_d = state_q;
    press_d = '0;
    rel_d   = '0;
    hold_d  = '0;
    rep_d   = '0;
    rise    = '0;
    fall    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      deb_d[c]  = deb_q[c];
      hcnt_d[c] = hcnt_q[c];
      fsm_d[c]  = fsm_q[c];

      // any return to the accepted level restarts the stability window
      if (raw[c] == state_q[c]) begin
        deb_d[c] = '0;
      end else if (tick) begin
        if (deb_q[c] == DW'(DEBOUNCE_MSEC - 1)) begin
          state_d[c] = raw[c];
          deb_d[c]   = '0;
          rise[c]    = raw[c];
          fall[c]    = !raw[c];
        end else begin
          deb_d[c] = deb_q[c] + 1'b1;
        end
      end
      press_d[c] = rise[c];
      rel_d[c]   = fall[c];

      unique case (fsm_q[c])
        IDLE: begin
          if (rise[c]) begin
            fsm_d[c]  = PRESSED;
            hcnt_d[c] = '0;
          end
        end
        PRESSED: begin
          if (fall[c]) begin
            fsm_d[c]  = IDLE;
            hcnt_d[c] = '0;
          end else if (tick) begin
            if (hcnt_q[c] == HW'(HOLD_MSEC - 1)) begin
              fsm_d[c]  = HELD;
              hcnt_d[c] = '0;
              hold_d[c] = 1'b1;
            end else begin
              hcnt_d[c] = hcnt_q[c] + 1'b1;
            end
          end
        end
        HELD: begin
          if (fall[c]) begin
            fsm_d[c]  = IDLE;
            hcnt_d[c] = '0;
          end else if (REPEAT_MSEC > 0 && tick) begin
            if (hcnt_q[c] == HW'(REPEAT_MSEC - 1)) begin
              hcnt_d[c] = '0;
              rep_d[c]  = 1'b1;
            end else begin
              hcnt_d[c] = hcnt_q[c] + 1'b1;
            end
          end
        end
        default: begin
          fsm_d[c]  = IDLE;
          hcnt_d[c] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      pre_q   <= '0;
      sync1_q <= IDLE_LVL;
      sync2_q <= IDLE_LVL;
      state_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      hold_q  <= '0;
      rep_q   <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        deb_q[c]  <= '0;
        hcnt_q[c] <= '0;
        fsm_q[c]  <= IDLE;
      end
    end else begin
      pre_q   <= pre_d;
      sync1_q <= bus.PIN;
      sync2_q <= sync1_q;
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      hold_q  <= hold_d;
      rep_q   <= rep_d;
      for (int c = 0; c < CHANNELS; c++) begin
        deb_q[c]  <= deb_d[c];
        hcnt_q[c] <= hcnt_d[c];
        fsm_q[c]  <= fsm_d[c];
      end
    end
  end

  assign bus.STATE   = state_q;
  assign bus.PRESS   = press_q;
  assign bus.RELEASE = rel_q;
  assign bus.HOLD    = hold_q;
  assign bus.REPEAT  = rep_q;
endmodule
